// File: rtl/serial_link_receiver_pkg.sv
// Purpose : shared types and constants for the serial link receiver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package serial_link_receiver_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Line levels: the link idles low, a high bit starts a frame, and a
    // well-formed frame ends with a low stop bit.
    localparam logic IDLE_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b0;

endpackage

// File: rtl/link_rx_fifo.sv
// Purpose : 2-entry in-order word buffer with registered head and overflow pulse.
// Latency : a push into an empty buffer is visible on head_dat/head_vld the next cycle.
// Backpressure: pop_rdy low holds the head; a push into a full buffer without a
//               same-cycle pop is dropped and overflow pulses for one cycle.
// Ports   : clk, rst (async, active-high); push_vld/push_dat write side;
//           head_vld/head_dat/pop_rdy read side; overflow drop indication.
module link_rx_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic             overflow
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             head_vld_q, head_vld_d;
    logic             tail_vld_q, tail_vld_d;
    logic             overflow_q, overflow_d;
    logic             pop;

    assign pop = head_vld_q & pop_rdy;

    // Pop is applied first, so a same-cycle push sees the freed slot: with one
    // entry held the new word lands in the head, with two it lands in the tail.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        overflow_d = 1'b0;

        if (pop) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end

        if (push_vld) begin
            if (!head_vld_d) begin
                head_d     = push_dat;
                head_vld_d = 1'b1;
            end else if (!tail_vld_d) begin
                tail_d     = push_dat;
                tail_vld_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_dat = head_q;
    assign head_vld = head_vld_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/serial_link_receiver.sv
// Purpose : deserialises start/payload(LSB first)/parity/stop frames into a 2-word buffer.
// Latency : a good word is on output_data one CLK after its stop bit is sampled (empty buffer).
// Backpressure: output_ready low holds the head word; a third good frame while
//               two are held is dropped with an overflow pulse.
// Ports   : CLK, RST (async, active-high); input_data serial line;
//           output_data/output_valid/output_ready word handshake;
//           parity_err, frame_err, overflow one-cycle error pulses.
module serial_link_receiver
    import serial_link_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PARITY_EN  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  input_data,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overflow
);

    // Wide enough to count 0..DATA_WIDTH, so the counter never wraps mid-frame.
    localparam int CW = $clog2(DATA_WIDTH + 1);

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  push;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;

        case (state_q)
            IDLE: begin
                if (input_data != IDLE_LEVEL) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    // Without a parity bit the frame is always parity-good.
                    par_bad_d = 1'b0;
                end
            end
            DATA: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shift_d[i] = input_data;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                // Even parity: payload XOR parity bit must be 0.
                par_bad_d = (^shift_q) ^ input_data;
                state_d   = STOP;
            end
            STOP: begin
                // Always back to IDLE, so a high stop bit is never a start bit.
                state_d = IDLE;
                if (input_data == STOP_LEVEL) begin
                    if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

    link_rx_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push_vld (push),
        .push_dat (shift_q),
        .pop_rdy  (output_ready),
        .head_dat (output_data),
        .head_vld (output_valid),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_serial_link_receiver.sv
// Purpose : directed self-checking bench for serial_link_receiver.
// Latency : n/a.
// Backpressure: output_ready driven directly by the directed sequence.
module tb_serial_link_receiver;

    logic       CLK;
    logic       RST;
    logic       input_data;
    logic [7:0] output_data;
    logic       output_valid;
    logic       output_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_link_receiver #(
        .DATA_WIDTH (8),
        .PARITY_EN  (1)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .input_data   (input_data),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge samples them.
    task automatic bit_out(input logic b);
        @(negedge CLK);
        input_data = b;
    endtask

    // Start, payload LSB first, parity, stop, then one idle bit so that on
    // return the stop bit has been sampled and registered outputs are visible.
    task automatic frame(input logic [7:0] d, input logic p, input logic s);
        bit_out(1'b1);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(p);
        bit_out(s);
        bit_out(1'b0);
    endtask

    initial begin
        logic saw_valid;
        RST          = 1'b1;
        input_data   = 1'b0;
        output_ready = 1'b1;

        // Reset held for three cycles.
        repeat (3) @(negedge CLK);
        check("rst_valid", 32'(output_valid), 32'h0);
        check("rst_data",  32'(output_data),  32'h0);
        check("rst_perr",  32'(parity_err),   32'h0);
        check("rst_ferr",  32'(frame_err),    32'h0);
        check("rst_ovf",   32'(overflow),     32'h0);
        RST = 1'b0;
        repeat (4) bit_out(1'b0);
        check("idle_valid", 32'(output_valid), 32'h0);
        check("idle_pulses", 32'({parity_err, frame_err, overflow}), 32'h0);

        // Good frame A5 (four ones -> parity 0).
        frame(8'hA5, 1'b0, 1'b0);
        check("a5_valid", 32'(output_valid), 32'h1);
        check("a5_data",  32'(output_data),  32'hA5);
        check("a5_perr",  32'(parity_err),   32'h0);
        check("a5_ferr",  32'(frame_err),    32'h0);
        bit_out(1'b0);
        check("a5_consumed", 32'(output_valid), 32'h0);

        // Same payload, wrong parity bit.
        frame(8'hA5, 1'b1, 1'b0);
        check("perr_pulse", 32'(parity_err),   32'h1);
        check("perr_valid", 32'(output_valid), 32'h0);
        bit_out(1'b0);
        check("perr_single", 32'(parity_err),  32'h0);
        check("perr_novalid", 32'(output_valid), 32'h0);

        // Bad stop bit; a high stop bit must not start a new frame.
        frame(8'h3C, 1'b0, 1'b1);
        check("ferr_pulse", 32'(frame_err),    32'h1);
        check("ferr_valid", 32'(output_valid), 32'h0);
        check("ferr_noperr", 32'(parity_err),  32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bit_out(1'b0);
            saw_valid = saw_valid | output_valid;
        end
        check("ferr_no_restart", 32'(saw_valid), 32'h0);
        check("ferr_single", 32'(frame_err), 32'h0);

        // Next good frame 01 (one one -> parity 1).
        frame(8'h01, 1'b1, 1'b0);
        check("f01_valid", 32'(output_valid), 32'h1);
        check("f01_data",  32'(output_data),  32'h01);
        check("f01_perr",  32'(parity_err),   32'h0);
        bit_out(1'b0);

        // Overflow: two words held, third dropped.
        output_ready = 1'b0;
        frame(8'h11, 1'b0, 1'b0);
        check("ov_11_valid", 32'(output_valid), 32'h1);
        check("ov_11_data",  32'(output_data),  32'h11);
        frame(8'h22, 1'b0, 1'b0);
        check("ov_22_head", 32'(output_data), 32'h11);
        check("ov_22_noovf", 32'(overflow),   32'h0);
        frame(8'h33, 1'b0, 1'b0);
        check("ov_33_pulse", 32'(overflow),   32'h1);
        check("ov_33_head",  32'(output_data), 32'h11);
        bit_out(1'b0);
        check("ov_single", 32'(overflow), 32'h0);
        output_ready = 1'b1;
        check("drain_w0_valid", 32'(output_valid), 32'h1);
        check("drain_w0_data",  32'(output_data),  32'h11);
        bit_out(1'b0);
        check("drain_w1_valid", 32'(output_valid), 32'h1);
        check("drain_w1_data",  32'(output_data),  32'h22);
        bit_out(1'b0);
        check("drain_empty", 32'(output_valid), 32'h0);

        // Buffered word plus a partial frame, then asynchronous reset at payload bit 4.
        output_ready = 1'b0;
        frame(8'h55, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(output_valid), 32'h1);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b1);
        #2;
        RST        = 1'b1;
        input_data = 1'b0;
        #1;
        check("arst_valid", 32'(output_valid), 32'h0);
        check("arst_data",  32'(output_data),  32'h0);
        @(negedge CLK);
        RST          = 1'b0;
        output_ready = 1'b1;
        repeat (3) bit_out(1'b0);
        check("post_rst_valid", 32'(output_valid), 32'h0);
        frame(8'h7E, 1'b0, 1'b0);
        check("f7e_valid", 32'(output_valid), 32'h1);
        check("f7e_data",  32'(output_data),  32'h7E);
        check("f7e_errs",  32'({parity_err, frame_err, overflow}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
